// File: rtl/awb_gain_estimator_pkg.sv
// Shared encodings and types for the auto-white-balance gain estimator.
package awb_gain_estimator_pkg;

  // Method codes, shared with the white-balance datapath.
  localparam logic [1:0] METHOD_MANUAL            = 2'b00;
  localparam logic [1:0] METHOD_GRAY_WORLD        = 2'b01;
  localparam logic [1:0] METHOD_PERFECT_REFLECTOR = 2'b10;
  localparam logic [1:0] METHOD_AUTO              = 2'b11;

  // Unity gain in Q8.8.
  localparam logic [15:0] GAIN_ONE = 16'h0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV_R,
    ST_DIV_B,
    ST_UPDATE
  } awb_state_e;

endpackage

// File: rtl/awb_serial_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle.
// A start loads the operands; NUM_WIDTH step cycles follow. done is high in
// the last step cycle, and quotient then shows the final (post-step) result,
// so the caller can capture it and restart the divider in the same cycle.
module awb_serial_divider
  import awb_gain_estimator_pkg::*;
#(
  parameter int NUM_WIDTH = 40,
  parameter int DEN_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] numerator,
  input  logic [DEN_WIDTH-1:0] denominator,
  output logic                 done,
  output logic [NUM_WIDTH-1:0] quotient,
  output logic                 div_by_zero
);

  localparam int CNT_WIDTH = $clog2(NUM_WIDTH + 1);

  logic [NUM_WIDTH-1:0] q_reg, q_step;
  logic [DEN_WIDTH-1:0] rem_reg, rem_step, den_reg;
  logic [DEN_WIDTH:0]   rem_sh;
  logic [CNT_WIDTH-1:0] cnt;

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    rem_sh   = {rem_reg, q_reg[NUM_WIDTH-1]};
    rem_step = rem_sh[DEN_WIDTH-1:0];
    q_step   = {q_reg[NUM_WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, den_reg}) begin
      rem_step = DEN_WIDTH'(rem_sh - {1'b0, den_reg});
      q_step   = {q_reg[NUM_WIDTH-2:0], 1'b1};
    end
  end

  assign done     = (cnt == CNT_WIDTH'(1));
  assign quotient = q_step;

  // Operand load on start, otherwise step while the down-counter runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      rem_reg     <= '0;
      den_reg     <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else if (start) begin
      q_reg       <= numerator;
      rem_reg     <= '0;
      den_reg     <= denominator;
      cnt         <= CNT_WIDTH'(NUM_WIDTH);
      div_by_zero <= (denominator == '0);
    end else if (cnt != '0) begin
      q_reg   <= q_step;
      rem_reg <= rem_step;
      cnt     <= cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/awb_gain_estimator.sv
// Per-frame RGB statistics and white-balance gain computation.
//
// state     | meaning
// ST_IDLE   | waiting for frame_end; snapshot taken here
// ST_LOAD   | operands selected, divider started on R
// ST_DIV_R  | dividing numerator by R denominator
// ST_DIV_B  | dividing numerator by B denominator
// ST_UPDATE | clamped gains published next edge
module awb_gain_estimator
  import awb_gain_estimator_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    GAIN_WIDTH = 16,
  parameter int                    ACC_WIDTH  = 32,
  parameter logic [GAIN_WIDTH-1:0] GAIN_MAX   = 16'h0400,
  parameter logic [GAIN_WIDTH-1:0] GAIN_MIN   = 16'h0040,
  parameter logic [DATA_WIDTH-1:0] SAT_THRESH = 8'd250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pixel_valid,
  input  logic [DATA_WIDTH-1:0] pixel_r,
  input  logic [DATA_WIDTH-1:0] pixel_g,
  input  logic [DATA_WIDTH-1:0] pixel_b,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic [1:0]            method,
  output logic [GAIN_WIDTH-1:0] gain_r,
  output logic [GAIN_WIDTH-1:0] gain_g,
  output logic [GAIN_WIDTH-1:0] gain_b,
  output logic                  gain_valid,
  output logic                  busy,
  output logic                  frame_dropped
);

  localparam int NUM_WIDTH = ACC_WIDTH + 8;
  localparam int ACC_W1    = ACC_WIDTH + 1;
  localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY = GAIN_WIDTH'(GAIN_ONE);

  // Channel index 0 = R, 1 = G, 2 = B.
  logic [2:0][DATA_WIDTH-1:0] pix;
  logic [2:0][ACC_WIDTH-1:0]  sum_q, sum_nxt, snap_sum;
  logic [2:0][DATA_WIDTH-1:0] max_q, max_nxt, snap_max;
  logic [ACC_WIDTH-1:0]       cnt_q, cnt_nxt;
  logic [ACC_W1-1:0]          sum_wide;
  logic [1:0]                 snap_method;
  logic                       accept, snap_en;

  awb_state_e state, state_nxt;

  logic [NUM_WIDTH-1:0]  div_num, div_quot;
  logic [ACC_WIDTH-1:0]  den_r, den_b, div_den;
  logic                  div_start, div_done, div_dz, num_zero;
  logic [GAIN_WIDTH-1:0] gr_q, gb_q;

  assign pix     = {pixel_b, pixel_g, pixel_r};
  assign accept  = pixel_valid && (pixel_r < SAT_THRESH) &&
                   (pixel_g < SAT_THRESH) && (pixel_b < SAT_THRESH);
  assign busy    = (state != ST_IDLE);
  assign snap_en = frame_end && (state == ST_IDLE);

  function automatic logic [GAIN_WIDTH-1:0] clamp_gain(input logic [NUM_WIDTH-1:0] q,
                                                       input logic dz, input logic nz);
    if (dz) return nz ? GAIN_UNITY : GAIN_MAX;
    if (q > NUM_WIDTH'(GAIN_MAX)) return GAIN_MAX;
    if (q < NUM_WIDTH'(GAIN_MIN)) return GAIN_MIN;
    return q[GAIN_WIDTH-1:0];
  endfunction

  // Next-cycle statistics: frame_start clears, accepted pixel accumulates with saturation.
  always_comb begin
    sum_wide = '0;
    cnt_nxt  = frame_start ? '0 : cnt_q;
    if (accept && (cnt_nxt != '1)) cnt_nxt = cnt_nxt + ACC_WIDTH'(1);
    for (int c = 0; c < 3; c++) begin
      sum_nxt[c] = frame_start ? '0 : sum_q[c];
      max_nxt[c] = frame_start ? '0 : max_q[c];
      if (accept) begin
        sum_wide   = {1'b0, sum_nxt[c]} + ACC_W1'(pix[c]);
        sum_nxt[c] = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
        if (pix[c] > max_nxt[c]) max_nxt[c] = pix[c];
      end
    end
  end

  // Live accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_nxt;
      max_q <= max_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Snapshot includes the pixel on the frame_end cycle; frozen while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_sum    <= '0;
      snap_max    <= '0;
      snap_method <= METHOD_MANUAL;
    end else if (snap_en) begin
      snap_sum    <= sum_nxt;
      snap_max    <= max_nxt;
      snap_method <= method;
    end
  end

  // Operand selection; gray world covers both 01 and the auto code.
  always_comb begin
    div_num = {snap_sum[1], 8'h00};
    den_r   = snap_sum[0];
    den_b   = snap_sum[2];
    if (snap_method == METHOD_PERFECT_REFLECTOR) begin
      div_num = NUM_WIDTH'({snap_max[1], 8'h00});
      den_r   = ACC_WIDTH'(snap_max[0]);
      den_b   = ACC_WIDTH'(snap_max[2]);
    end
    num_zero = (div_num == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and divider sequencing; B restarts in the same cycle R finishes.
  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    div_den   = den_r;
    case (state)
      ST_IDLE: begin
        if (frame_end && (method != METHOD_MANUAL) && (cnt_nxt != '0)) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        div_start = 1'b1;
        state_nxt = ST_DIV_R;
      end
      ST_DIV_R: begin
        if (div_done) begin
          div_start = 1'b1;
          div_den   = den_b;
          state_nxt = ST_DIV_B;
        end
      end
      ST_DIV_B: begin
        if (div_done) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  awb_serial_divider #(
    .NUM_WIDTH (NUM_WIDTH),
    .DEN_WIDTH (ACC_WIDTH)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (div_start),
    .numerator   (div_num),
    .denominator (div_den),
    .done        (div_done),
    .quotient    (div_quot),
    .div_by_zero (div_dz)
  );

  // Capture clamped quotients as each division completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gr_q <= GAIN_UNITY;
      gb_q <= GAIN_UNITY;
    end else if (div_done && (state == ST_DIV_R)) begin
      gr_q <= clamp_gain(div_quot, div_dz, num_zero);
    end else if (div_done && (state == ST_DIV_B)) begin
      gb_q <= clamp_gain(div_quot, div_dz, num_zero);
    end
  end

  // Atomic gain publish with one-cycle strobe; dropped-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_r        <= GAIN_UNITY;
      gain_g        <= GAIN_UNITY;
      gain_b        <= GAIN_UNITY;
      gain_valid    <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      gain_valid    <= (state == ST_UPDATE);
      frame_dropped <= frame_end && busy;
      if (state == ST_UPDATE) begin
        gain_r <= gr_q;
        gain_g <= GAIN_UNITY;
        gain_b <= gb_q;
      end
    end
  end

endmodule

// File: tb/tb_awb_gain_estimator.sv
// Directed bench for awb_gain_estimator with hand-computed expected gains.
module tb_awb_gain_estimator;

  logic        clk, rst_n;
  logic        pixel_valid, frame_start, frame_end;
  logic [7:0]  pixel_r, pixel_g, pixel_b;
  logic [1:0]  method;
  logic [15:0] gain_r, gain_g, gain_b;
  logic        gain_valid, busy, frame_dropped;

  int checks = 0;
  int errors = 0;

  awb_gain_estimator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixel_valid   (pixel_valid),
    .pixel_r       (pixel_r),
    .pixel_g       (pixel_g),
    .pixel_b       (pixel_b),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .method        (method),
    .gain_r        (gain_r),
    .gain_g        (gain_g),
    .gain_b        (gain_b),
    .gain_valid    (gain_valid),
    .busy          (busy),
    .frame_dropped (frame_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pixel cycle, driven at a negedge; returns at the following negedge.
  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic fs, input logic fe);
    pixel_valid = 1'b1; pixel_r = r; pixel_g = g; pixel_b = b;
    frame_start = fs; frame_end = fe;
    @(negedge clk);
    pixel_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
  endtask

  // Called one cycle after frame_end; lat = cycles from frame_end, 0 on timeout.
  task automatic wait_gain(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      if (gain_valid) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic watch_idle(input int n, output int nvalid, output int nbusy);
    nvalid = 0; nbusy = 0;
    for (int k = 0; k < n; k++) begin
      if (gain_valid) nvalid++;
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    checks++; if (gain_r !== 16'h0100) begin errors++; $display("FAIL reset_gain_r: got %h expected 0100", gain_r); end
    checks++; if (gain_g !== 16'h0100) begin errors++; $display("FAIL reset_gain_g: got %h expected 0100", gain_g); end
    checks++; if (gain_b !== 16'h0100) begin errors++; $display("FAIL reset_gain_b: got %h expected 0100", gain_b); end
    checks++; if (gain_valid !== 1'b0) begin errors++; $display("FAIL reset_gain_valid: got %b expected 0", gain_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", frame_dropped); end
  endtask

  // Sums R=256 G=512 B=128: 131072/256=0x200, 131072/128=0x400.
  task automatic test_gray_world;
    int lat;
    method = 2'b01;
    pix(64, 128, 32, 1'b1, 1'b0);
    pix(64, 128, 32, 1'b0, 1'b0);
    pix(64, 128, 32, 1'b0, 1'b0);
    pix(64, 128, 32, 1'b0, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gw_busy_start: got %b expected 1", busy); end
    wait_gain(lat);
    checks++; if (lat !== 83) begin errors++; $display("FAIL gw_latency: got %0d expected 83", lat); end
    checks++; if (gain_r !== 16'h0200) begin errors++; $display("FAIL gw_gain_r: got %h expected 0200", gain_r); end
    checks++; if (gain_g !== 16'h0100) begin errors++; $display("FAIL gw_gain_g: got %h expected 0100", gain_g); end
    checks++; if (gain_b !== 16'h0400) begin errors++; $display("FAIL gw_gain_b: got %h expected 0400", gain_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gw_busy_end: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (gain_valid !== 1'b0) begin errors++; $display("FAIL gw_valid_pulse: got %b expected 0", gain_valid); end
  endtask

  // Maxima R=100 G=200 B=50: 51200/100=0x200, 51200/50=0x400 (sums would give 0x224).
  task automatic test_perfect_reflector;
    int lat;
    method = 2'b10;
    pix(100, 200, 50, 1'b1, 1'b0);
    pix(40, 100, 25, 1'b0, 1'b1);
    wait_gain(lat);
    checks++; if (lat !== 83) begin errors++; $display("FAIL pr_latency: got %0d expected 83", lat); end
    checks++; if (gain_r !== 16'h0200) begin errors++; $display("FAIL pr_gain_r: got %h expected 0200", gain_r); end
    checks++; if (gain_b !== 16'h0400) begin errors++; $display("FAIL pr_gain_b: got %h expected 0400", gain_b); end
  endtask

  // 51200/1 clamps to 0x400, 51200/240=213=0xD5; then 5120/200=25 clamps to 0x40, 5120/20=0x100.
  task automatic test_clamp;
    int lat;
    method = 2'b01;
    pix(1, 200, 240, 1'b1, 1'b1);
    wait_gain(lat);
    checks++; if (gain_r !== 16'h0400) begin errors++; $display("FAIL clamp_hi_r: got %h expected 0400", gain_r); end
    checks++; if (gain_b !== 16'h00D5) begin errors++; $display("FAIL clamp_trunc_b: got %h expected 00d5", gain_b); end
    pix(200, 20, 20, 1'b1, 1'b1);
    wait_gain(lat);
    checks++; if (gain_r !== 16'h0040) begin errors++; $display("FAIL clamp_lo_r: got %h expected 0040", gain_r); end
    checks++; if (gain_b !== 16'h0100) begin errors++; $display("FAIL clamp_unity_b: got %h expected 0100", gain_b); end
  endtask

  task automatic test_no_update;
    int nv, nb;
    method = 2'b01;
    pix(255, 255, 255, 1'b1, 1'b0);
    pix(250, 10, 10, 1'b0, 1'b0);
    pix(10, 10, 255, 1'b0, 1'b1);
    watch_idle(100, nv, nb);
    checks++; if (nv !== 0) begin errors++; $display("FAIL sat_no_valid: got %0d pulses expected 0", nv); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL sat_no_busy: got %0d busy cycles expected 0", nb); end
    method = 2'b00;
    pix(64, 128, 32, 1'b1, 1'b0);
    pix(64, 128, 32, 1'b0, 1'b1);
    watch_idle(100, nv, nb);
    checks++; if (nv !== 0) begin errors++; $display("FAIL hold_no_valid: got %0d pulses expected 0", nv); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL hold_no_busy: got %0d busy cycles expected 0", nb); end
    checks++; if (gain_r !== 16'h0040) begin errors++; $display("FAIL hold_gain_r: got %h expected 0040", gain_r); end
    checks++; if (gain_b !== 16'h0100) begin errors++; $display("FAIL hold_gain_b: got %h expected 0100", gain_b); end
  endtask

  // 249 accepted, 250 excluded: 25600/249=102=0x66, 25600/100=0x100.
  task automatic test_sat_boundary;
    int lat;
    method = 2'b11;
    pix(249, 100, 100, 1'b1, 1'b0);
    pix(250, 200, 200, 1'b0, 1'b1);
    wait_gain(lat);
    checks++; if (lat !== 83) begin errors++; $display("FAIL satb_latency: got %0d expected 83", lat); end
    checks++; if (gain_r !== 16'h0066) begin errors++; $display("FAIL satb_gain_r: got %h expected 0066", gain_r); end
    checks++; if (gain_b !== 16'h0100) begin errors++; $display("FAIL satb_gain_b: got %h expected 0100", gain_b); end
  endtask

  // Second frame_end at T+30 is dropped; frame_start at T+20 must not disturb the result.
  task automatic test_back_to_back;
    int lat, drops, drop_at;
    method = 2'b01;
    pix(64, 128, 32, 1'b1, 1'b0);
    pix(64, 128, 32, 1'b0, 1'b0);
    pix(64, 128, 32, 1'b0, 1'b0);
    pix(64, 128, 32, 1'b0, 1'b1);
    lat = 0; drops = 0; drop_at = 0;
    for (int k = 1; k <= 200; k++) begin
      if (frame_dropped) begin drops++; drop_at = k; end
      if (k == 82) begin
        checks++; if (gain_r !== 16'h0066) begin errors++; $display("FAIL b2b_gain_stable: got %h expected 0066", gain_r); end
      end
      if (gain_valid) begin lat = k; break; end
      pixel_valid = (k == 20) || (k == 30);
      pixel_r = 8'd10; pixel_g = 8'd10; pixel_b = 8'd10;
      frame_start = (k == 20);
      frame_end   = (k == 30);
      @(negedge clk);
    end
    pixel_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    checks++; if (drops !== 1) begin errors++; $display("FAIL b2b_drop_count: got %0d expected 1", drops); end
    checks++; if (drop_at !== 31) begin errors++; $display("FAIL b2b_drop_cycle: got %0d expected 31", drop_at); end
    checks++; if (lat !== 83) begin errors++; $display("FAIL b2b_latency: got %0d expected 83", lat); end
    checks++; if (gain_r !== 16'h0200) begin errors++; $display("FAIL b2b_gain_r: got %h expected 0200", gain_r); end
    checks++; if (gain_b !== 16'h0400) begin errors++; $display("FAIL b2b_gain_b: got %h expected 0400", gain_b); end
  endtask

  task automatic test_reset_mid;
    int nv, nb;
    method = 2'b01;
    pix(50, 100, 200, 1'b1, 1'b1);
    repeat (39) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (gain_r !== 16'h0100) begin errors++; $display("FAIL rstmid_gain_r: got %h expected 0100", gain_r); end
    checks++; if (gain_b !== 16'h0100) begin errors++; $display("FAIL rstmid_gain_b: got %h expected 0100", gain_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    watch_idle(100, nv, nb);
    checks++; if (nv !== 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d pulses expected 0", nv); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL rstmid_no_busy: got %0d busy cycles expected 0", nb); end
  endtask

  initial begin
    rst_n = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    pixel_r = '0; pixel_g = '0; pixel_b = '0; method = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_gray_world();
    test_perfect_reflector();
    test_clamp();
    test_no_update();
    test_sat_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
